// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus of seq_multiplier.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     ina;
    logic [WIDTH-1:0]     inb;
    logic                 is_signed;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   out;

    modport master (output start, ina, inb, is_signed, input busy, done, out);
    modport slave  (input start, ina, inb, is_signed, output busy, done, out);
endinterface

// File: rtl/seq_mult_datapath.sv
// Partial-product, multiplicand and multiplier registers with the shift-add step.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   sum_c
);
    localparam int unsigned PW = 2 * WIDTH;

    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    // Value the partial product takes on this step; exposed so the last step can be captured.
    assign sum_c = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            prod_d   = '0;
            mcand_d  = PW'(a_i);
            mplier_d = b_i;
        end else if (step_i) begin
            prod_d   = sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: FSM, iteration counter, handshake and sign fix-up.
// Signed operation is built only when SEQ_MULT_SIGNED_EN is defined.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_multiplier_if.slave   bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = cnt_w(WIDTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [PW-1:0]       out_q, out_d;
    logic                load_c, step_c;
    logic [WIDTH-1:0]    a_mag_c, b_mag_c;
    logic [PW-1:0]       sum_c, result_c;

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;

    // Magnitudes as WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1).
    assign a_mag_c  = (bus.is_signed && bus.ina[WIDTH-1]) ? (~bus.ina + WIDTH'(1)) : bus.ina;
    assign b_mag_c  = (bus.is_signed && bus.inb[WIDTH-1]) ? (~bus.inb + WIDTH'(1)) : bus.inb;
    assign result_c = sign_q ? (~sum_c + PW'(1)) : sum_c;
`else
    logic is_signed_unused;

    assign is_signed_unused = bus.is_signed;
    assign a_mag_c          = bus.ina;
    assign b_mag_c          = bus.inb;
    assign result_c         = sum_c;
`endif

    seq_mult_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_c),
        .step_i (step_c),
        .a_i    (a_mag_c),
        .b_i    (b_mag_c),
        .sum_c  (sum_c)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    load_c  = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = RUN;
`ifdef SEQ_MULT_SIGNED_EN
                    sign_d  = bus.is_signed & (bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1]);
`endif
                end
            end
            RUN: begin
                step_c = 1'b1;
                cnt_d  = cnt_q - CNT_W'(1);
                // Final step: capture the completed sum, never a partial one.
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = result_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised iterative shift-add multiplier, one multiplier bit per clock, with a start/busy/done handshake. It produces a 2*WIDTH-bit product. Successor to the fixed 8-bit unsigned sequential multiplier, adding:
- an explicit FSM,
- asynchronous reset,
- a correctly sized iteration counter for any WIDTH,
- a one-cycle done pulse and held result,
- optional signed operands.

It sits between arithmetic datapaths and control FSMs that can tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; operands sampled on the accepting edge
ina  input  WIDTH  multiplicand
inb  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands (only with SEQ_MULT_SIGNED_EN)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when out becomes valid
out  output  2*WIDTH  product; held until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, out=0, counter=0, internal registers=0. Reset mid-operation aborts it with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - latch operand magnitudes, partial product=0, counter=WIDTH.
  - next state RUN; busy=1.
- RUN, each cycle:
  - if multiplier LSB=1, partial product += multiplicand (2*WIDTH-bit add, no overflow possible).
  - multiplicand <<= 1; multiplier >>= 1; counter -= 1.
  - on the cycle counter goes 1->0: load out (applying the sign fix-up), done=1, busy=0, next state DONE.
- DONE: done returns to 0 after one cycle; out is held; state remains DONE until start.
- Latency:
  - start accepted at edge N; done=1 and out valid after edge N+WIDTH.
  - new start is accepted in the cycle done is high (back-to-back throughput: one result per WIDTH cycles).
- start while busy=1: ignored; operands are not resampled and the running operation is unaffected.
- out changes only on the completion edge or on reset. It never shows partial values.
- Counter must be CNT_W bits so that WIDTH=16, 32, etc. terminate correctly.

Optional Feature:
Macro SEQ_MULT_SIGNED_EN.
- Defined, and is_signed=1 at start:
  - magnitudes of ina/inb are taken (WIDTH-bit unsigned, so the most-negative value maps to 2^(WIDTH-1)).
  - sign bit = ina[MSB] XOR inb[MSB] is latched.
  - at completion, out = two's-complement negation of the product if the sign bit is 1.
  - latency is unchanged.
- Defined, and is_signed=0: unsigned operation.
- Undefined: is_signed is ignored, all operation is unsigned, and no negation logic is synthesised.

Decomposition:
- Package seq_mult_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - localparam helper for CNT_W.
- One natural sub-module: seq_mult_datapath, containing the partial-product, multiplicand and multiplier registers and the adder. It has load/step controls.
- The top holds the FSM, counter, handshake and sign fix-up.

Test Plan (WIDTH=8 unless noted):
- ina=255, inb=255, start pulse -> done high exactly 8 cycles after the accepting edge, out=65025 (0xFE01); busy high for those 8 cycles.
- ina=0, inb=173; then ina=1, inb=200 issued back-to-back on the done cycle -> out=0 then out=200; no extra idle cycle between operations.
- Mid-RUN start with ina=3, inb=3 -> ignored; the original 12*10 completes with out=120.
- Reset asserted 4 cycles into 100*100 -> busy=0, done never pulses, out=0 immediately without waiting for a clock edge.
- SEQ_MULT_SIGNED_EN, is_signed=1:
  - -3*5 -> out=0xFFF1.
  - -128*-128 -> out=16384.
  - -128*127 -> out=0xC080.
  - with is_signed=0, 0xFD*0x05 -> out=1265.
- WIDTH=16: 65535*65535 -> out=0xFFFE0001 after exactly 16 cycles (checks counter sizing).
